ternary_mac_sequencer: RTL and testbench
========================================

Name: ternary_mac_sequencer

Overview:
- Sequences the ternary matrix-vector datapath: weight-load phase, bit-serial multiply passes, and result hand-off.
- Replaces the free-running LOAD/MULT counter in the top level.
- Drives the weight loader's enable and row index, and the multiplier's bit-select.
- Adds start/abort control, input back-pressure and an output valid/ready handshake.

Parameters:
- MAX_IN_LEN, 8, activations per row (informational; passed through to the sibling loader/multiplier).
- MAX_OUT_LEN, 4, maximum weight rows; legal 1..7.
- BIT_WIDTH, 8, activation bits per multiply pass; legal 2..8.
- MULT_LATENCY, 2, cycles from the last bit-select beat until the multiplier result is stable; legal 0..7.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a job; sampled in IDLE only.
- abort  input  1  synchronous job cancel; return to IDLE next cycle.
- cfg_rows  input  3  weight rows to load; 0 is treated as MAX_OUT_LEN, values above MAX_OUT_LEN are clamped to it. Latched on start.
- cfg_passes  input  8  multiply passes per job; 0 means run passes until abort. Latched on start.
- in_valid  input  1  upstream beat (weight row or activation slice) present on the shared input bus.
- in_ready  output  1  beat accepted this cycle when in_valid && in_ready.
- load_ena  output  1  weight loader captures the bus this cycle.
- load_row  output  3  row index being written.
- mult_bit_sel  output  3  bit index fed to the multiplier.
- mult_ena  output  1  multiplier accumulates this cycle.
- out_valid  output  1  result on the multiplier output is valid.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a job completes normally.

Behaviour:
- Reset (rst=1 at a clock edge) forces the state machine to IDLE and all counters to 0.
  - Every output is 0 during and after reset until start.
  - rst overrides abort and start; reset mid-job discards the job.
- IDLE:
  - in_ready=0.
  - On start=1: latch the effective rows R and passes P, clear row/bit/pass/latency counters, go to LOAD.
- LOAD:
  - in_ready=1 and load_ena=in_valid.
  - load_row = row counter; it increments on each accepted beat.
  - If in_valid=0, everything holds and load_ena=0.
  - On the accepted beat with row counter = R-1: clear the counter and go to MULT next cycle.
  - Exactly R beats are consumed.
- MULT:
  - in_ready=1 and mult_ena=in_valid.
  - mult_bit_sel = bit counter, starting at 0 and incrementing on each accepted beat.
  - A stalled beat holds mult_bit_sel.
  - On the accepted beat with bit counter = BIT_WIDTH-1: clear the counter and go to WAIT.
- WAIT:
  - in_ready=0, mult_ena=0.
  - Count MULT_LATENCY cycles, then go to OUTPUT.
  - With MULT_LATENCY=0, go directly from MULT to OUTPUT.
- OUTPUT:
  - out_valid=1 and held until out_ready=1; in_ready=0.
  - On handshake, increment the pass counter.
  - If P≠0 and pass counter = P: pulse done for one cycle and go to IDLE.
  - Otherwise return to MULT with the bit counter at 0; weights are not reloaded.
- abort=1 in any non-IDLE state: next state is IDLE, counters clear, no done pulse.
  - An in-flight beat that is accepted in the same cycle is ignored.
- start in a non-IDLE state is ignored; start and abort together in IDLE means abort wins (stay IDLE).
- Counter widths:
  - row and bit counters: 3 bits.
  - latency counter: 3 bits.
  - pass counter: 8 bits; with P=0 it wraps 255→0 without effect.
- done and out_valid are registered; all other outputs are decoded from registered state and counters. No combinational path from out_ready to in_ready.

Test Plan:
1. Reset then start with cfg_rows=4, cfg_passes=1, in_valid held high → load_ena high 4 cycles with load_row 0,1,2,3. Then mult_bit_sel 0..7 over 8 cycles, 2 WAIT cycles, out_valid. With out_ready=1, done pulses exactly once and busy drops; 16 cycles from start to done.
2. in_valid toggled 1,0,1,0 during LOAD with cfg_rows=2 → load_row holds during gaps; exactly 2 load_ena pulses; MULT entered after the 2nd accepted beat.
3. cfg_passes=3, out_ready held low 5 cycles on the first result → out_valid stays high and mult_ena low throughout. After three handshakes done pulses once; no reload (load_ena never re-asserts).
4. abort asserted at mult_bit_sel=5 → next cycle IDLE, all outputs 0, no done. A following start with cfg_rows=0 loads 4 rows.
5. rst asserted mid-WAIT together with abort and start → IDLE with all outputs 0 next cycle. start during LOAD has no effect on load_row.
6. cfg_passes=0 → continuous passes past 256 handshakes with no done; abort terminates the job.

Source files
------------

// File: rtl/ternary_mac_sequencer.sv
// ternary_mac_sequencer: phase sequencer for the ternary matrix-vector datapath (weight load, bit-serial multiply passes, result hand-off)
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start, abort      job request (honoured in IDLE only); job cancel
//   cfg_rows          weight rows to load; 0 or above MAX_OUT_LEN means MAX_OUT_LEN
//   cfg_passes        multiply passes per job; 0 means run until abort
//   in_valid/in_ready shared input bus handshake (weight rows, then activation slices)
//   load_ena/load_row weight loader write strobe and row index
//   mult_ena/mult_bit_sel multiplier accumulate strobe and bit index
//   out_valid/out_ready result hand-off handshake
//   busy, done        not-IDLE flag; one-cycle normal-completion pulse
module ternary_mac_sequencer #(
    parameter int MAX_IN_LEN   = 8,
    parameter int MAX_OUT_LEN  = 4,
    parameter int BIT_WIDTH    = 8,
    parameter int MULT_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] cfg_rows,
    input  logic [7:0] cfg_passes,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load_ena,
    output logic [2:0] load_row,
    output logic [2:0] mult_bit_sel,
    output logic       mult_ena,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);
    if (MAX_IN_LEN < 1 || MAX_OUT_LEN < 1 || MAX_OUT_LEN > 7 || BIT_WIDTH < 2 || BIT_WIDTH > 8 ||
        MULT_LATENCY < 0 || MULT_LATENCY > 7) begin : g_param_check
        $error("ternary_mac_sequencer: illegal parameter value");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MULT, S_WAIT, S_OUTPUT} state_e;

    state_e     state_q, state_d;
    logic [2:0] rows_q, rows_d;
    logic [7:0] passes_q, passes_d;
    logic [2:0] row_q, row_d;
    logic [2:0] bit_q, bit_d;
    logic [2:0] lat_q, lat_d;
    logic [7:0] pass_q, pass_d;
    logic       done_q, done_d;
    logic       out_valid_q, out_valid_d;
    logic [2:0] eff_rows;

    assign eff_rows = (cfg_rows == 3'd0 || cfg_rows > 3'(MAX_OUT_LEN)) ? 3'(MAX_OUT_LEN) : cfg_rows;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rows_q      <= '0;
            passes_q    <= '0;
            row_q       <= '0;
            bit_q       <= '0;
            lat_q       <= '0;
            pass_q      <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            passes_q    <= passes_d;
            row_q       <= row_d;
            bit_q       <= bit_d;
            lat_q       <= lat_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        passes_d = passes_q;
        row_d    = row_q;
        bit_d    = bit_q;
        lat_d    = lat_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    rows_d   = eff_rows;
                    passes_d = cfg_passes;
                    row_d    = '0;
                    bit_d    = '0;
                    lat_d    = '0;
                    pass_d   = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    row_d   = (row_q == rows_q - 3'd1) ? 3'd0 : row_q + 3'd1;
                    state_d = (row_q == rows_q - 3'd1) ? S_MULT : S_LOAD;
                end
            end
            S_MULT: begin
                if (in_valid) begin
                    bit_d   = (bit_q == 3'(BIT_WIDTH - 1)) ? 3'd0 : bit_q + 3'd1;
                    state_d = (bit_q != 3'(BIT_WIDTH - 1)) ? S_MULT :
                              (MULT_LATENCY == 0) ? S_OUTPUT : S_WAIT;
                end
            end
            S_WAIT: begin
                lat_d   = (lat_q == 3'(MULT_LATENCY - 1)) ? 3'd0 : lat_q + 3'd1;
                state_d = (lat_q == 3'(MULT_LATENCY - 1)) ? S_OUTPUT : S_WAIT;
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    pass_d = pass_q + 8'd1;
                    // passes_q == 0 runs forever; pass_q simply wraps
                    done_d  = (passes_q != 8'd0) && (pass_d == passes_q);
                    state_d = done_d ? S_IDLE : S_MULT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort discards any beat accepted in the same cycle
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            row_d   = '0;
            bit_d   = '0;
            lat_d   = '0;
            pass_d  = '0;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        in_ready     = (state_q == S_LOAD) || (state_q == S_MULT);
        load_ena     = (state_q == S_LOAD) && in_valid;
        mult_ena     = (state_q == S_MULT) && in_valid;
        load_row     = row_q;
        mult_bit_sel = bit_q;
        busy         = (state_q != S_IDLE);
        out_valid_d  = (state_d == S_OUTPUT);
    end

    assign out_valid = out_valid_q;
    assign done      = done_q;
endmodule

// File: tb/tb_ternary_mac_sequencer.sv
// tb_ternary_mac_sequencer: self-checking bench for ternary_mac_sequencer
module tb_ternary_mac_sequencer;
    logic       clk, rst, start, abort, in_valid, out_ready;
    logic [2:0] cfg_rows;
    logic [7:0] cfg_passes;
    logic       in_ready, load_ena, mult_ena, out_valid, busy, done;
    logic [2:0] load_row, mult_bit_sel;
    logic [11:0] outs;
    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];
    int row_q[$];
    int bit_q[$];

    ternary_mac_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_rows(cfg_rows), .cfg_passes(cfg_passes),
        .in_valid(in_valid), .in_ready(in_ready),
        .load_ena(load_ena), .load_row(load_row),
        .mult_bit_sel(mult_bit_sel), .mult_ena(mult_ena),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    assign outs = {in_ready, load_ena, load_row, mult_ena, mult_bit_sel, out_valid, busy, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [11:0] ev(bit ir, bit le, int row, bit me, int bs, bit ov, bit b, bit d);
        return {ir, le, 3'(row), me, 3'(bs), ov, b, d};
    endfunction

    task automatic kick(input int r, input int p);
        cfg_rows = 3'(r);
        cfg_passes = 8'(p);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cfg_rows = 3'd2; cfg_passes = 8'd1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (outs !== 12'd0) $display("FAIL reset_outs: got %b expected %b", outs, 12'd0);
        if (outs !== 12'd0) errors++;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (outs !== 12'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected %b", outs, 12'd0);
        end
    endtask

    task automatic test_basic();
        exp_q = {};
        for (int c = 0; c < 4; c++) exp_q.push_back(ev(1, 1, c, 0, 0, 0, 1, 0));
        for (int b = 0; b < 8; b++) exp_q.push_back(ev(1, 0, 0, 1, b, 0, 1, 0));
        repeat (2) exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(ev(0, 0, 0, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        in_valid = 1'b1; out_ready = 1'b1;
        #2;
        kick(4, 1);
        for (int c = 1; exp_q.size() > 0; c++) begin
            logic [11:0] e;
            #1;
            e = exp_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL basic_cycle%0d: got %b expected %b", c, outs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_stall();
        exp_q = {};
        exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 1, 0));
        exp_q.push_back(ev(1, 1, 1, 0, 0, 0, 1, 0));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 1, 0));
        for (int b = 0; b < 3; b++) exp_q.push_back(ev(1, 0, 0, 1, b, 0, 1, 0));
        exp_q.push_back(ev(1, 0, 0, 0, 3, 0, 1, 0));
        for (int b = 3; b < 8; b++) exp_q.push_back(ev(1, 0, 0, 1, b, 0, 1, 0));
        repeat (2) exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(ev(0, 0, 0, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
        out_ready = 1'b1;
        kick(2, 1);
        for (int c = 1; exp_q.size() > 0; c++) begin
            logic [11:0] e;
            in_valid = (c == 2 || c == 4 || c == 8) ? 1'b0 : 1'b1;
            #1;
            e = exp_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL stall_cycle%0d: got %b expected %b", c, outs, e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
    endtask

    task automatic test_back_to_back();
        int ov_low = 0, hs = 0, nload = 0, nd = 0, done_cyc = 0, viol = 0;
        bit_q = {};
        repeat (3) for (int b = 0; b < 8; b++) bit_q.push_back(b);
        in_valid = 1'b1; out_ready = 1'b1;
        kick(1, 3);
        for (int c = 1; c <= 60 && nd == 0; c++) begin
            if (out_valid === 1'b1 && hs == 0 && ov_low < 5) begin
                out_ready = 1'b0;
                ov_low++;
            end else out_ready = 1'b1;
            #1;
            if (out_valid === 1'b1 && (mult_ena !== 1'b0 || in_ready !== 1'b0)) viol++;
            if (out_valid === 1'b1 && out_ready) hs++;
            if (load_ena === 1'b1) nload++;
            if (done === 1'b1) begin
                nd++;
                done_cyc = c;
            end
            if (mult_ena === 1'b1) begin
                int e;
                e = (bit_q.size() > 0) ? bit_q.pop_front() : -1;
                checks++;
                if (int'(mult_bit_sel) !== e) begin
                    errors++;
                    $display("FAIL b2b_bit_sel: got %0d expected %0d", mult_bit_sel, e);
                end
            end
            @(posedge clk);
            #1;
        end
        #1;
        checks += 8;
        if (viol !== 0) begin errors++; $display("FAIL b2b_stall_outputs: got %0d bad cycles expected 0", viol); end
        if (ov_low !== 5) begin errors++; $display("FAIL b2b_held_valid: got %0d expected 5", ov_low); end
        if (hs !== 3) begin errors++; $display("FAIL b2b_handshakes: got %0d expected 3", hs); end
        if (nd !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", nd); end
        if (done_cyc !== 40) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 40", done_cyc); end
        if (nload !== 1) begin errors++; $display("FAIL b2b_no_reload: got %0d expected 1", nload); end
        if (bit_q.size() !== 0) begin errors++; $display("FAIL b2b_bits_left: got %0d expected 0", bit_q.size()); end
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_abort();
        bit found = 0;
        int nd = 0, nb = 0, nload = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        kick(4, 1);
        for (int c = 0; c < 30; c++) begin
            #1;
            if (mult_ena === 1'b1 && mult_bit_sel === 3'd5) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL abort_reach_bit5: got %0d expected 1", found); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        #1;
        checks++;
        if (outs !== 12'd0) begin errors++; $display("FAIL abort_idle: got %b expected %b", outs, 12'd0); end
        repeat (20) begin
            @(posedge clk);
            #2;
            if (done === 1'b1) nd++;
            if (busy !== 1'b0) nb++;
        end
        checks++;
        if (nd !== 0 || nb !== 0) begin errors++; $display("FAIL abort_no_done: got done=%0d busy=%0d expected 0 0", nd, nb); end
        row_q = {};
        for (int r = 0; r < 4; r++) row_q.push_back(r);
        #1;
        kick(0, 1);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (mult_ena === 1'b1) break;
            if (load_ena === 1'b1) begin
                int e;
                e = (row_q.size() > 0) ? row_q.pop_front() : -1;
                checks++;
                if (int'(load_row) !== e) begin errors++; $display("FAIL rows0_load_row: got %0d expected %0d", load_row, e); end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (row_q.size() !== 0) begin errors++; $display("FAIL rows0_count: got %0d rows left expected 0", row_q.size()); end
        #1;
        do_abort();
        kick(7, 1);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (mult_ena === 1'b1) break;
            if (load_ena === 1'b1) nload++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (nload !== 4) begin errors++; $display("FAIL rows7_clamp: got %0d expected 4", nload); end
        #1;
        do_abort();
    endtask

    task automatic test_reset_mid_job();
        in_valid = 1'b1; out_ready = 1'b1;
        kick(1, 1);
        repeat (9) @(posedge clk);
        #2;
        checks++;
        if (outs !== ev(0, 0, 0, 0, 0, 0, 1, 0)) begin errors++; $display("FAIL wait_state: got %b expected %b", outs, ev(0, 0, 0, 0, 0, 0, 1, 0)); end
        rst = 1'b1; abort = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        #1;
        checks++;
        if (outs !== 12'd0) begin errors++; $display("FAIL rst_mid_wait: got %b expected %b", outs, 12'd0); end
        @(posedge clk);
        #2;
        checks++;
        if (outs !== 12'd0) begin errors++; $display("FAIL rst_stays_idle: got %b expected %b", outs, 12'd0); end
        row_q = {};
        for (int r = 0; r < 3; r++) row_q.push_back(r);
        kick(3, 1);
        for (int c = 1; c < 20; c++) begin
            start = (c == 2) ? 1'b1 : 1'b0;
            cfg_rows = (c == 2) ? 3'd1 : 3'd3;
            #1;
            if (mult_ena === 1'b1) break;
            if (load_ena === 1'b1) begin
                int e;
                e = (row_q.size() > 0) ? row_q.pop_front() : -1;
                checks++;
                if (int'(load_row) !== e) begin errors++; $display("FAIL start_in_load_row: got %0d expected %0d", load_row, e); end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++;
        if (row_q.size() !== 0) begin errors++; $display("FAIL start_in_load_count: got %0d rows left expected 0", row_q.size()); end
        #1;
        do_abort();
    endtask

    task automatic test_infinite();
        int hs = 0, nd = 0, nb = 0, nload = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        kick(1, 0);
        for (int c = 0; c < 4000; c++) begin
            #1;
            if (load_ena === 1'b1) nload++;
            if (done === 1'b1) nd++;
            if (busy !== 1'b1) nb++;
            if (out_valid === 1'b1) hs++;
            if (hs == 260) break;
            @(posedge clk);
            #1;
        end
        checks += 4;
        if (hs !== 260) begin errors++; $display("FAIL inf_handshakes: got %0d expected 260", hs); end
        if (nd !== 0) begin errors++; $display("FAIL inf_no_done: got %0d expected 0", nd); end
        if (nb !== 0) begin errors++; $display("FAIL inf_busy: got %0d idle cycles expected 0", nb); end
        if (nload !== 1) begin errors++; $display("FAIL inf_no_reload: got %0d expected 1", nload); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        #1;
        checks++;
        if (outs !== 12'd0) begin errors++; $display("FAIL inf_abort: got %b expected %b", outs, 12'd0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_stall();
        test_back_to_back();
        test_abort();
        test_reset_mid_job();
        test_infinite();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
